// File: rtl/mult_accum.sv
// mult_accum: accumulates a programmed number of PW-bit products into an AW-bit sum.
// Build option SATURATE_EN: clamp acc at 2^AW-1 on carry instead of wrapping.
module mult_accum #(
    parameter int PW = 4,
    parameter int AW = 8,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [LW-1:0] len_i,
    input  logic          prod_valid_i,
    input  logic [PW-1:0] prod_i,
    output logic          prod_ready_o,
    output logic [AW-1:0] acc_o,
    output logic          done_o,
    output logic          busy_o,
    output logic          ovf_o
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t        state_q, state_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] acc_q, acc_d;
    logic          ovf_q, ovf_d;
    logic [AW:0]   sum;
    logic          hs;
    assign sum = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, prod_i};
    assign hs  = prod_valid_i && (state_q == ACC);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (start_i) begin
                cnt_d   = len_i;
                acc_d   = '0;
                ovf_d   = 1'b0;
                state_d = (len_i != '0) ? ACC : DONE;
            end
            ACC: if (hs) begin
                cnt_d   = cnt_q - 1'b1;
                ovf_d   = ovf_q | sum[AW];
`ifdef SATURATE_EN
                // once clamped, any further add carries again, so acc stays at max
                acc_d   = sum[AW] ? '1 : sum[AW-1:0];
`else
                acc_d   = sum[AW-1:0];
`endif
                state_d = (cnt_q == LW'(1)) ? DONE : ACC;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign prod_ready_o = (state_q == ACC);
    assign done_o       = (state_q == DONE);
    assign busy_o       = (state_q != IDLE);
    assign acc_o        = acc_q;
    assign ovf_o        = ovf_q;
endmodule

// File: tb/tb_mult_accum.sv
// tb_mult_accum: drives an AW=8 and an AW=7 accumulator in parallel and checks both against an unbounded-sum model.
module tb_mult_accum;
    localparam int SAT =
`ifdef SATURATE_EN
        1;
`else
        0;
`endif
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, prod_valid = 1'b0;
    logic [3:0] len = '0, prod = '0;
    logic       ready8, done8, busy8, ovf8, ready7, done7, busy7, ovf7;
    logic [7:0] acc8;
    logic [6:0] acc7;
    int checks = 0, failures = 0, dcount = 0;
    int m_ph = 0, m_sum = 0, m_rem = 0;

    mult_accum #(.PW(4), .AW(8), .LW(4)) u8 (
        .clk(clk), .rst(rst), .start_i(start), .len_i(len), .prod_valid_i(prod_valid),
        .prod_i(prod), .prod_ready_o(ready8), .acc_o(acc8), .done_o(done8), .busy_o(busy8), .ovf_o(ovf8)
    );
    mult_accum #(.PW(4), .AW(7), .LW(4)) u7 (
        .clk(clk), .rst(rst), .start_i(start), .len_i(len), .prod_valid_i(prod_valid),
        .prod_i(prod), .prod_ready_o(ready7), .acc_o(acc7), .done_o(done7), .busy_o(busy7), .ovf_o(ovf7)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_acc(input int s, input int aw);
        int mx = (1 << aw) - 1;
        return SAT ? ((s > mx) ? mx : s) : (s & mx);
    endfunction

    // phase 0 = idle, 1 = collecting products, 2 = completion cycle; the sum is kept unbounded
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= 0; m_sum <= 0; m_rem <= 0;
        end else if (m_ph == 0) begin
            if (start) begin
                m_sum <= 0;
                m_rem <= int'(len);
                m_ph  <= (len != 0) ? 1 : 2;
            end
        end else if (m_ph == 1) begin
            if (prod_valid) begin
                m_sum <= m_sum + int'(prod);
                m_rem <= m_rem - 1;
                if (m_rem == 1) m_ph <= 2;
            end
        end else m_ph <= 0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("ready8", int'(ready8), int'(m_ph == 1));
            chk("busy8",  int'(busy8),  int'(m_ph != 0));
            chk("done8",  int'(done8),  int'(m_ph == 2));
            chk("acc8",   int'(acc8),   exp_acc(m_sum, 8));
            chk("ovf8",   int'(ovf8),   int'(m_sum > 255));
            chk("ready7", int'(ready7), int'(m_ph == 1));
            chk("done7",  int'(done7),  int'(m_ph == 2));
            chk("acc7",   int'(acc7),   exp_acc(m_sum, 7));
            chk("ovf7",   int'(ovf7),   int'(m_sum > 127));
            if (done8) dcount++;
        end
    end

    task automatic do_start(input int n);
        @(posedge clk); #2;
        start = 1'b1; len = 4'(n);
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic send(input int p, input int gap);
        logic hs = 1'b0;
        repeat (gap) begin @(posedge clk); #2; end
        prod_valid = 1'b1; prod = 4'(p);
        for (int k = 0; k < 50 && !hs; k++) begin
            @(negedge clk); hs = ready8;
            @(posedge clk); #2;
        end
        prod_valid = 1'b0;
        if (!hs) chk("handshake_timeout", 0, 1);
    endtask

    task automatic finish_run(input string name, input int a8, input int o8, input int a7, input int o7);
        @(negedge clk);
        chk({name, "_done"}, int'(done8), 1);
        chk({name, "_ready"}, int'(ready8), 0);
        chk({name, "_acc8"}, int'(acc8), a8);
        chk({name, "_ovf8"}, int'(ovf8), o8);
        chk({name, "_acc7"}, int'(acc7), a7);
        chk({name, "_ovf7"}, int'(ovf7), o7);
        @(posedge clk); #2;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        chk("rst_acc", int'(acc8), 0);
        chk("rst_busy", int'(busy8), 0);
        chk("rst_ready", int'(ready8), 0);
        chk("rst_done", int'(done8), 0);
        #2 rst = 1'b0;
        // basic run
        do_start(3);
        for (int i = 0; i < 3; i++) send(6, 0);
        finish_run("basic", 18, 0, 18, 0);
        // gaps between products
        dcount = 0;
        do_start(3);
        for (int i = 0; i < 3; i++) send(6, 2);
        finish_run("gaps", 18, 0, 18, 0);
        repeat (2) @(posedge clk);
        chk("gaps_done_count", dcount, 1);
        // max length, sum 225
        do_start(15);
        for (int i = 0; i < 15; i++) send(15, 0);
        finish_run("ovfA", 225, 0, SAT ? 127 : 97, 1);
        // sum 220
        do_start(15);
        for (int i = 0; i < 15; i++) send(i < 10 ? 15 : 14, i % 3);
        finish_run("ovfB", 220, 0, SAT ? 127 : 92, 1);
        repeat (3) @(posedge clk);
        chk("hold_acc7", int'(acc7), SAT ? 127 : 92);
        // zero length
        do_start(0);
        finish_run("zero", 0, 0, 0, 0);
        // start ignored while collecting
        do_start(3);
        send(6, 0);
        start = 1'b1; len = 4'd5;
        @(posedge clk); #2;
        start = 1'b0;
        send(6, 0);
        send(6, 1);
        finish_run("busy_start", 18, 0, 18, 0);
        // asynchronous reset mid-run
        do_start(4);
        send(15, 0);
        send(15, 0);
        #1 rst = 1'b1;
        #1;
        chk("mrst_acc", int'(acc8), 0);
        chk("mrst_ovf", int'(ovf8), 0);
        chk("mrst_busy", int'(busy8), 0);
        chk("mrst_ready", int'(ready8), 0);
        chk("mrst_done", int'(done8), 0);
        @(negedge clk); #2 rst = 1'b0;
        do_start(2);
        send(4, 0);
        send(5, 0);
        finish_run("after_rst", 9, 0, 9, 0);
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
